// File: rtl/rtc_runcontrol_if.sv
// Button inputs and run-control outputs between the stopwatch
// control block and the logic that drives or observes it.
interface rtc_runcontrol_if;
  logic       i_start_stop;
  logic       i_lap_reset;
  logic       o_count_enb;
  logic       o_count_init;
  logic       o_latch_count;
  logic [1:0] o_state;
  logic [3:0] o_lap_num;

  modport master (
    output i_start_stop,
    output i_lap_reset,
    input  o_count_enb,
    input  o_count_init,
    input  o_latch_count,
    input  o_state,
    input  o_lap_num
  );

  modport slave (
    input  i_start_stop,
    input  i_lap_reset,
    output o_count_enb,
    output o_count_init,
    output o_latch_count,
    output o_state,
    output o_lap_num
  );
endinterface

// File: rtl/rtc_runcontrol.sv
// Stopwatch run/lap/clear sequencer: per-button synchronizer and debouncer
// feeding an IDLE/RUN/LAP/STOP state machine with registered outputs.
module rtc_runcontrol #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                i_sclk,
  input  logic                i_reset,
  rtc_runcontrol_if.slave     bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  logic [1:0] raw;
  logic [1:0] press;

  assign raw = {bus.i_lap_reset, bus.i_start_stop};

  // Index 0 is start/stop, index 1 is lap/reset.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic          sync1_q;
      logic          sync2_q;
      logic          deb_q;
      logic          deb_d;
      logic          deb_prev_q;
      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;

      // Counter runs only while the synchronized level disagrees with the
      // debounced one; the flip happens on the edge after it reaches the limit.
      always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
          if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
            deb_d = ~deb_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge i_sclk) begin
        if (i_reset) begin
          sync1_q    <= 1'b0;
          sync2_q    <= 1'b0;
          deb_q      <= 1'b0;
          deb_prev_q <= 1'b0;
          cnt_q      <= '0;
        end else begin
          sync1_q    <= raw[gi];
          sync2_q    <= sync1_q;
          deb_q      <= deb_d;
          deb_prev_q <= deb_q;
          cnt_q      <= cnt_d;
        end
      end

      assign press[gi] = deb_q & ~deb_prev_q;
    end
  endgenerate

  state_t     state_q, state_d;
  logic [3:0] lap_q, lap_d;
  logic       init_q, init_d;
  logic       enb_q, enb_d;
  logic       latch_q, latch_d;
  logic       ss_evt, lr_evt;

  // A start/stop press masks a lap/reset press arriving in the same cycle.
  assign ss_evt = press[0];
  assign lr_evt = press[1] & ~press[0];

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    init_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_evt) begin
          state_d = RUN;
        end else if (lr_evt) begin
          init_d = 1'b1;
          lap_d  = 4'd0;
        end
      end
      RUN: begin
        if (ss_evt) begin
          state_d = STOP;
        end else if (lr_evt) begin
          state_d = LAP;
          lap_d   = lap_q + 4'd1;
        end
      end
      LAP: begin
        if (ss_evt) begin
          state_d = STOP;
        end else if (lr_evt) begin
          state_d = RUN;
        end
      end
      STOP: begin
        if (ss_evt) begin
          state_d = RUN;
        end else if (lr_evt) begin
          state_d = IDLE;
          init_d  = 1'b1;
          lap_d   = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    enb_d   = (state_d == RUN) || (state_d == LAP);
    latch_d = (state_d == LAP);
  end

  always_ff @(posedge i_sclk) begin
    if (i_reset) begin
      state_q <= IDLE;
      lap_q   <= 4'd0;
      init_q  <= 1'b0;
      enb_q   <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lap_q   <= lap_d;
      init_q  <= init_d;
      enb_q   <= enb_d;
      latch_q <= latch_d;
    end
  end

  assign bus.o_count_enb   = enb_q;
  assign bus.o_count_init  = init_q;
  assign bus.o_latch_count = latch_q;
  assign bus.o_state       = state_q;
  assign bus.o_lap_num     = lap_q;

endmodule
